fpu_issue_seq16: RTL and testbench
==================================

# fpu_issue_seq16

Request sequencer sitting directly upstream of `fpu16`. It buffers operation requests in a small FIFO and issues them one at a time to `fpu16`. For FPU_MUL it pulses `start` and waits on `mulDone`, with a timeout guard. Each result is captured with its flags into a single-entry response register, handed downstream by valid/ready handshake in strict request order.

## Interface
- `DEPTH`, 4: request FIFO entries (power of two, ≥2)
- `TAG_W`, 4: width of the request tag carried through to the response
- `MUL_TIMEOUT`, 32: max cycles spent in MUL_WAIT before forced completion (≥2)
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset asserted)
- `reqValid`  in  1  request present
- `reqReady`  out  1  FIFO can accept; = (count < DEPTH)
- `reqOp`  in  fpuOp_t  operation
- `reqIn1`, `reqIn2`  in  fp16_t  operands
- `reqTag`  in  TAG_W  opaque tag
- `fpuIn1`, `fpuIn2`  out  fp16_t  operands to fpu16 (from issue register)
- `op`  out  fpuOp_t  operation to fpu16
- `start`  out  1  one-cycle multiply start pulse
- `fpuOut`  in  fp16_t  fpu16 result
- `mulDone`  in  1  fpu16 multiply complete
- `condCodes`  in  condCode_t; `statusFlags`  in  statusFlag_t; `comps`  in  fpuComp_t  from fpu16
- `rspValid`  out  1  response present
- `rspReady`  in  1  consumer accepts
- `rspOut`  out  fp16_t; `rspTag`  out  TAG_W; `rspCondCodes`  out  condCode_t; `rspStatusFlags`  out  statusFlag_t; `rspComps`  out  fpuComp_t
- `rspTimeout`  out  1  result forced by multiply timeout

## Operation
- Push when reqValid && reqReady. Pop only in IDLE, when FIFO non-empty and response slot free: rspValid==0, or rspValid && rspReady in the same cycle. Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, EXEC, MUL_WAIT.
  - IDLE: on pop, load the issue register {op, in1, in2, tag} from the FIFO head and go to EXEC.
  - EXEC, op != FPU_MUL: capture fpuOut, condCodes, statusFlags, comps and tag into the response register; set rspValid; rspTimeout=0; go to IDLE.
  - EXEC, op == FPU_MUL: start=1 for this cycle only; clear the timeout counter; go to MUL_WAIT.
  - MUL_WAIT: counter increments each cycle. If mulDone, capture as above and go to IDLE. Else if counter == MUL_TIMEOUT-1, capture with rspOut=FP16_QNAN (16'h7E00), NV flag set in rspStatusFlags, rspTimeout=1, and go to IDLE. mulDone wins over timeout in the same cycle.
- mulDone is sampled only in MUL_WAIT. fpu16 deasserts mulDone the cycle after start.
- The response register clears rspValid on rspValid && rspReady, unless it is reloaded in the same cycle. Response fields are held stable while rspValid && !rspReady.
- Responses appear in request order; tags pass through unmodified.

## Timing
- Reset values:
  - reqReady=1; rspValid=0; start=0; rspTimeout=0.
  - All rsp* data outputs 0.
  - fpuIn1/fpuIn2=0; op=FPU_ADD.
  - FSM=IDLE; FIFO count=0.
- Reset asserted mid-operation discards FIFO contents, the in-flight op and any pending response. No response is produced for them.
- Latency, non-MUL op into empty block: request accepted at edge E0; pop at E1; rspValid high after E2 (2 cycles).
- Latency, MUL: start high in the cycle after E1. The response appears the edge after mulDone is seen in MUL_WAIT. Worst case is E2+MUL_TIMEOUT.
- Throughput: one non-MUL op per 2 cycles; the FSM returns to IDLE before the next pop.
- Timeout counter width: $clog2(MUL_TIMEOUT+1).
- FIFO pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.

## Structure
- Shared package additions: `fpuSeqState_t` enum {IDLE, EXEC, MUL_WAIT}; `FP16_QNAN` constant 16'h7E00.
- Existing package types used unchanged: fp16_t, fpuOp_t, condCode_t, statusFlag_t, fpuComp_t.
- One sub-module: `fpuReqFifo`, a parameterized synchronous FIFO (DEPTH, payload width) with count output. The FSM and response register live in the top.

## Test plan
- ADD 16'h3C00 + 16'h4000, tag 3, rspReady=1 → rspValid exactly 2 cycles after accept; rspOut=16'h4200, rspTag=3, rspTimeout=0.
- MUL 16'h4000 × 16'h4200 with fpu16 attached → single start pulse, rspOut=16'h4600 after mulDone; no second start.
- MUL with mulDone held 0 by a bench stub, MUL_TIMEOUT=32 → rspValid after 32 MUL_WAIT cycles; rspOut=16'h7E00, rspTimeout=1, NV set.
- rspReady=0; push 6 requests (tags 0–5) back-to-back → 5 accepted and reqReady low on the 6th. Raise rspReady → responses in tag order 0–4, then tag 5 is accepted.
- Simultaneous push on a full FIFO while a response is consumed → no push that cycle, count stays DEPTH until the pop; no entry is lost or duplicated.
- reset=0 during MUL_WAIT with 2 entries queued → next cycle rspValid=0, start=0, reqReady=1. After release, no stale response appears.

Source files
------------

// File: rtl/fpu_issue_seq16_pkg.sv
// ============================================================================
// Module      : fpu_issue_seq16_pkg
// Description : Shared fpu16 types plus sequencer state and quiet-NaN constant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_issue_seq16_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [2:0] {
        FPU_ADD = 3'd0,
        FPU_SUB = 3'd1,
        FPU_MUL = 3'd2,
        FPU_CMP = 3'd3,
        FPU_NEG = 3'd4,
        FPU_ABS = 3'd5
    } fpuOp_t;

    typedef logic [3:0] condCode_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } statusFlag_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
        logic un;
    } fpuComp_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MUL_WAIT = 2'd2
    } fpuSeqState_t;

    localparam fp16_t FP16_QNAN = 16'h7E00;

endpackage

`default_nettype wire

// File: rtl/fpu_issue_seq16_fifo.sv
// ============================================================================
// Module      : fpuReqFifo
// Description : Synchronous first-word-fall-through request FIFO with count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpuReqFifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_pushData,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_popData,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_ptrW = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ptrW-1:0] r_wrPtr;
    logic [c_ptrW-1:0] r_rdPtr;

    always_ff @(posedge clock) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            o_count <= '0;
        end else begin
            if (i_push) r_wrPtr <= r_wrPtr + c_ptrW'(1);
            if (i_pop)  r_rdPtr <= r_rdPtr + c_ptrW'(1);
            case ({i_push, i_pop})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
        end
    end

    assign o_popData = r_mem[r_rdPtr];

endmodule

`default_nettype wire

// File: rtl/fpu_issue_seq16.sv
// ============================================================================
// Module      : fpu_issue_seq16
// Description : Buffers fpu16 requests, issues them in order, returns results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_issue_seq16
    import fpu_issue_seq16_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int MUL_TIMEOUT = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reqValid,
    output logic             reqReady,
    input  fpuOp_t           reqOp,
    input  fp16_t            reqIn1,
    input  fp16_t            reqIn2,
    input  logic [TAG_W-1:0] reqTag,
    output fp16_t            fpuIn1,
    output fp16_t            fpuIn2,
    output fpuOp_t           op,
    output logic             start,
    input  fp16_t            fpuOut,
    input  logic             mulDone,
    input  condCode_t        condCodes,
    input  statusFlag_t      statusFlags,
    input  fpuComp_t         comps,
    output logic             rspValid,
    input  logic             rspReady,
    output fp16_t            rspOut,
    output logic [TAG_W-1:0] rspTag,
    output condCode_t        rspCondCodes,
    output statusFlag_t      rspStatusFlags,
    output fpuComp_t         rspComps,
    output logic             rspTimeout
);

    localparam int c_opW      = $bits(fpuOp_t);
    localparam int c_payloadW = c_opW + 32 + TAG_W;
    localparam int c_countW   = $clog2(DEPTH + 1);
    localparam int c_cntW     = $clog2(MUL_TIMEOUT + 1);
    localparam logic [c_countW-1:0] c_full    = c_countW'(DEPTH);
    localparam logic [c_cntW-1:0]   c_cntLast = c_cntW'(MUL_TIMEOUT - 1);

    fpuSeqState_t          r_state;
    fpuSeqState_t          w_nextState;
    logic [c_cntW-1:0]     r_mulCnt;
    logic [TAG_W-1:0]      r_issueTag;
    logic [c_countW-1:0]   w_count;
    logic [c_payloadW-1:0] w_popData;
    logic [c_opW-1:0]      w_headOpBits;
    fp16_t                 w_headIn1;
    fp16_t                 w_headIn2;
    logic [TAG_W-1:0]      w_headTag;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_forceNan;
    logic                  w_timeoutHit;
    statusFlag_t           w_nanFlags;

    assign reqReady     = (w_count < c_full);
    assign w_push       = reqValid && reqReady;
    assign w_timeoutHit = (r_mulCnt == c_cntLast);
    assign {w_headOpBits, w_headIn1, w_headIn2, w_headTag} = w_popData;

    fpuReqFifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_payloadW)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_push),
        .i_pushData ({reqOp, reqIn1, reqIn2, reqTag}),
        .i_pop      (w_pop),
        .o_popData  (w_popData),
        .o_count    (w_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_pop) w_nextState = EXEC;
            EXEC:     w_nextState = (op == FPU_MUL) ? MUL_WAIT : IDLE;
            MUL_WAIT: if (mulDone || w_timeoutHit) w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // Pop only once the response slot is free or is being drained this cycle.
    always_comb begin
        w_pop      = 1'b0;
        start      = 1'b0;
        w_capture  = 1'b0;
        w_forceNan = 1'b0;
        case (r_state)
            IDLE: w_pop = (w_count != '0) && (!rspValid || rspReady);
            EXEC: begin
                if (op == FPU_MUL) start     = 1'b1;
                else               w_capture = 1'b1;
            end
            MUL_WAIT: begin
                if (mulDone) begin
                    w_capture = 1'b1;
                end else if (w_timeoutHit) begin
                    w_capture  = 1'b1;
                    w_forceNan = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_nanFlags    = statusFlags;
        w_nanFlags.nv = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op         <= FPU_ADD;
            fpuIn1     <= '0;
            fpuIn2     <= '0;
            r_issueTag <= '0;
            r_mulCnt   <= '0;
        end else begin
            if (w_pop) begin
                op         <= fpuOp_t'(w_headOpBits);
                fpuIn1     <= w_headIn1;
                fpuIn2     <= w_headIn2;
                r_issueTag <= w_headTag;
            end
            if (start)                  r_mulCnt <= '0;
            else if (r_state == MUL_WAIT) r_mulCnt <= r_mulCnt + c_cntW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rspValid       <= 1'b0;
            rspOut         <= '0;
            rspTag         <= '0;
            rspCondCodes   <= '0;
            rspStatusFlags <= '0;
            rspComps       <= '0;
            rspTimeout     <= 1'b0;
        end else if (w_capture) begin
            rspValid       <= 1'b1;
            rspOut         <= w_forceNan ? FP16_QNAN : fpuOut;
            rspTag         <= r_issueTag;
            rspCondCodes   <= condCodes;
            rspStatusFlags <= w_forceNan ? w_nanFlags : statusFlags;
            rspComps       <= comps;
            rspTimeout     <= w_forceNan;
        end else if (rspValid && rspReady) begin
            rspValid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_seq16.sv
// ============================================================================
// Module      : tb_fpu_issue_seq16
// Description : Scoreboard bench for fpu_issue_seq16 with an fpu16 stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_issue_seq16;
    import fpu_issue_seq16_pkg::*;

    localparam condCode_t c_CC    = 4'hA;
    localparam fpuComp_t  c_COMPS = 4'b0101;

    typedef struct packed {
        logic [15:0] out;
        logic [3:0]  tag;
        logic        to;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    fpuOp_t      reqOp;
    fp16_t       reqIn1;
    fp16_t       reqIn2;
    logic [3:0]  reqTag;
    fp16_t       fpuIn1;
    fp16_t       fpuIn2;
    fpuOp_t      op;
    logic        start;
    fp16_t       fpuOut;
    logic        mulDone;
    statusFlag_t statusFlags;
    logic        rspValid;
    logic        rspReady;
    fp16_t       rspOut;
    logic [3:0]  rspTag;
    condCode_t   rspCondCodes;
    statusFlag_t rspStatusFlags;
    fpuComp_t    rspComps;
    logic        rspTimeout;

    int   nCmp = 0;
    int   nFail = 0;
    int   startCount = 0;
    int   n;
    int   s0;
    int   waited;
    logic stubHang;
    logic [3:0] stubCnt;
    exp_t q[$];

    fpu_issue_seq16 #(.DEPTH(4), .TAG_W(4), .MUL_TIMEOUT(32)) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
        .reqIn1(reqIn1), .reqIn2(reqIn2), .reqTag(reqTag),
        .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .op(op), .start(start),
        .fpuOut(fpuOut), .mulDone(mulDone), .condCodes(c_CC),
        .statusFlags(statusFlags), .comps(c_COMPS),
        .rspValid(rspValid), .rspReady(rspReady), .rspOut(rspOut),
        .rspTag(rspTag), .rspCondCodes(rspCondCodes),
        .rspStatusFlags(rspStatusFlags), .rspComps(rspComps),
        .rspTimeout(rspTimeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // fpu16 stand-in: known results for the directed vectors, integer sum otherwise.
    always_comb begin
        if (op == FPU_ADD && fpuIn1 == 16'h3C00 && fpuIn2 == 16'h4000)      fpuOut = 16'h4200;
        else if (op == FPU_MUL && fpuIn1 == 16'h4000 && fpuIn2 == 16'h4200) fpuOut = 16'h4600;
        else                                                                 fpuOut = fpuIn1 + fpuIn2;
    end
    assign statusFlags = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset)                stubCnt <= 4'd0;
        else if (start && !stubHang) stubCnt <= 4'd3;
        else if (stubCnt != 4'd0)  stubCnt <= stubCnt - 4'd1;
    end
    assign mulDone = (stubCnt == 4'd1);

    always @(posedge clock) if (reset && start) startCount++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sendReq(input fpuOp_t o, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] t, input logic [15:0] eo, input logic eto,
                           input logic track, output int w);
        exp_t e;
        reqValid = 1'b1; reqOp = o; reqIn1 = a; reqIn2 = b; reqTag = t; w = 0;
        while (!reqReady && w < 50) begin
            tick();
            w++;
        end
        if (!reqReady) begin
            nCmp++; nFail++;
            $display("FAIL send_timeout: tag %0d not accepted, expected acceptance within 50 cycles", t);
        end else begin
            if (track) begin
                e.out = eo; e.tag = t; e.to = eto;
                q.push_back(e);
            end
            tick();
        end
        reqValid = 1'b0;
    endtask

    task automatic waitRsp(output int cycles);
        cycles = 0;
        while (!rspValid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    always @(negedge clock) begin
        if (reset && rspValid && rspReady) begin
            if (q.size() == 0) begin
                nCmp++; nFail++;
                $display("FAIL unexpected_rsp: got tag %0d, expected no response", rspTag);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_out", 32'(rspOut), 32'(e.out));
                check("rsp_tag", 32'(rspTag), 32'(e.tag));
                check("rsp_timeout", 32'(rspTimeout), 32'(e.to));
                check("rsp_flags", 32'(rspStatusFlags), e.to ? 32'h10 : 32'h0);
                check("rsp_cc", 32'(rspCondCodes), 32'hA);
                check("rsp_comps", 32'(rspComps), 32'h5);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; reqValid = 1'b0; reqOp = FPU_ADD; reqIn1 = '0; reqIn2 = '0;
        reqTag = '0; rspReady = 1'b0; stubHang = 1'b0;
        repeat (3) tick();
        check("rst_reqReady", 32'(reqReady), 1);
        check("rst_rspValid", 32'(rspValid), 0);
        check("rst_start", 32'(start), 0);
        check("rst_rspTimeout", 32'(rspTimeout), 0);
        check("rst_rspOut", 32'(rspOut), 0);
        check("rst_rspTag", 32'(rspTag), 0);
        check("rst_rspFlags", 32'(rspStatusFlags), 0);
        check("rst_fpuIn", 32'({fpuIn1, fpuIn2}), 0);
        check("rst_op", 32'(op), 32'(FPU_ADD));
        reset = 1'b1;
        tick();

        // Basic add: two-cycle latency.
        rspReady = 1'b1;
        sendReq(FPU_ADD, 16'h3C00, 16'h4000, 4'd3, 16'h4200, 1'b0, 1'b1, waited);
        waitRsp(n);
        check("add_latency", n, 2);
        tick();

        // Multiply with completion from the stand-in after three wait cycles.
        s0 = startCount;
        sendReq(FPU_MUL, 16'h4000, 16'h4200, 4'd7, 16'h4600, 1'b0, 1'b1, waited);
        waitRsp(n);
        check("mul_latency", n, 5);
        repeat (4) tick();
        check("mul_start_pulses", startCount - s0, 1);

        // Multiply that never completes: forced QNaN after 32 wait cycles.
        stubHang = 1'b1;
        sendReq(FPU_MUL, 16'h4000, 16'h4200, 4'd9, 16'h7E00, 1'b1, 1'b1, waited);
        waitRsp(n);
        check("timeout_latency", n, 34);
        repeat (2) tick();
        stubHang = 1'b0;

        // Backlog with consumer stalled: one in the response slot plus four queued.
        rspReady = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("backlog_ready", 32'(reqReady), 1);
            sendReq(FPU_ADD, 16'h1000 + 16'(i), 16'h0010, 4'(i), 16'h1010 + 16'(i), 1'b0, 1'b1, waited);
        end
        reqValid = 1'b1; reqOp = FPU_ADD; reqIn1 = 16'h1005; reqIn2 = 16'h0010; reqTag = 4'd5;
        repeat (3) begin
            check("full_ready_low", 32'(reqReady), 0);
            tick();
        end
        rspReady = 1'b1;
        check("full_at_consume", 32'(reqReady), 0);
        sendReq(FPU_ADD, 16'h1005, 16'h0010, 4'd5, 16'h1015, 1'b0, 1'b1, waited);
        check("push_blocked_cycles", waited, 1);
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", q.size(), 0);
        repeat (2) tick();

        // Reset while a multiply waits with two requests queued behind it.
        stubHang = 1'b1;
        sendReq(FPU_MUL, 16'h4000, 16'h4200, 4'd10, 16'h0, 1'b0, 1'b0, waited);
        sendReq(FPU_ADD, 16'h2000, 16'h0001, 4'd11, 16'h0, 1'b0, 1'b0, waited);
        sendReq(FPU_ADD, 16'h2000, 16'h0002, 4'd12, 16'h0, 1'b0, 1'b0, waited);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("mid_rst_rspValid", 32'(rspValid), 0);
        check("mid_rst_start", 32'(start), 0);
        check("mid_rst_reqReady", 32'(reqReady), 1);
        tick();
        reset = 1'b1;
        stubHang = 1'b0;
        repeat (40) tick();
        check("no_stale_rsp", 32'(rspValid), 0);

        sendReq(FPU_ADD, 16'h3C00, 16'h4000, 4'd1, 16'h4200, 1'b0, 1'b1, waited);
        waitRsp(n);
        check("post_rst_latency", n, 2);
        repeat (3) tick();
        check("final_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

`default_nettype wire
